imm_gen_pipe: RTL and testbench

- Parametrised, pipelined immediate generator for the decode stage.
- Accepts a full 32-bit instruction word and identifies its format (R/I/S/B/U/J) from the opcode, or takes the format from an explicit override.
- Produces the XLEN-wide sign-extended immediate plus format and illegal flags.
- Valid/ready handshake with a 2-entry skid buffer: full throughput under backpressure, one cycle of latency, no combinational ready path.

---
 rtl/riscv_imm_pkg.sv | 35 +++
 rtl/imm_fmt_decode.sv | 91 +++++++++
 rtl/imm_gen_pipe.sv | 110 +++++++++++
 tb/tb_imm_gen_pipe.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_imm_pkg.sv
// riscv_imm_pkg: opcode constants and format codes shared by the
// immediate generator and its decoder.
package riscv_imm_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_REG32  = 7'b0111011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_e;

  function automatic logic fmt_legal(
    input logic [2:0] f
  );
    return f <= FMT_J;
  endfunction

endpackage

// File: rtl/imm_fmt_decode.sv
// imm_fmt_decode: combinational format decode and immediate assembly.
// Ports: i_instr/i_fmt/i_fmt_vld in; o_imm (XLEN), o_fmt, o_illegal out.
module imm_fmt_decode
  import riscv_imm_pkg::*;
#(
  parameter int XLEN            = 32,
  parameter int FMT_OVERRIDE_EN = 0
) (
  input  logic [31:0]     i_instr,
  input  logic [2:0]      i_fmt,
  input  logic            i_fmt_vld,
  output logic [XLEN-1:0] o_imm,
  output logic [2:0]      o_fmt,
  output logic            o_illegal
);

  logic [6:0]  w_op;
  logic [2:0]  w_dec;
  logic [2:0]  w_fmt;
  logic [31:0] w_imm32;

  assign w_op = i_instr[6:0];

  always_comb begin
    w_dec = FMT_ILL;
    unique case (1'b1)
      (w_op == OP_REG),
      (w_op == OP_REG32 && XLEN == 64):
        w_dec = FMT_R;
      (w_op == OP_IMM),
      (w_op == OP_LOAD),
      (w_op == OP_JALR),
      (w_op == OP_SYSTEM),
      (w_op == OP_FENCE),
      (w_op == OP_IMM32 && XLEN == 64):
        w_dec = FMT_I;
      (w_op == OP_STORE):
        w_dec = FMT_S;
      (w_op == OP_BRANCH):
        w_dec = FMT_B;
      (w_op == OP_LUI),
      (w_op == OP_AUIPC):
        w_dec = FMT_U;
      (w_op == OP_JAL):
        w_dec = FMT_J;
      default:
        w_dec = FMT_ILL;
    endcase
  end

  assign w_fmt = (FMT_OVERRIDE_EN != 0 && i_fmt_vld)
               ? i_fmt : w_dec;

  always_comb begin
    w_imm32 = '0;
    unique case (w_fmt)
      FMT_I:
        w_imm32 = {{20{i_instr[31]}},
                   i_instr[31:20]};
      FMT_S:
        w_imm32 = {{20{i_instr[31]}},
                   i_instr[31:25],
                   i_instr[11:7]};
      FMT_B:
        w_imm32 = {{19{i_instr[31]}},
                   i_instr[31], i_instr[7],
                   i_instr[30:25],
                   i_instr[11:8], 1'b0};
      FMT_U:
        w_imm32 = {i_instr[31:12], 12'b0};
      FMT_J:
        w_imm32 = {{11{i_instr[31]}},
                   i_instr[31],
                   i_instr[19:12],
                   i_instr[20],
                   i_instr[30:21], 1'b0};
      default:
        w_imm32 = '0;
    endcase
  end

  // widen to XLEN: fill with the sign, then drop in the low word
  always_comb begin
    o_imm       = {XLEN{w_imm32[31]}};
    o_imm[31:0] = w_imm32;
  end

  assign o_fmt     = w_fmt;
  assign o_illegal = !fmt_legal(w_fmt);

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: one-cycle immediate generator with 2-entry skid buffer.
// Ports: in_* handshake + instr/tag/fmt; out_* handshake + imm/fmt/illegal/tag.
module imm_gen_pipe
  import riscv_imm_pkg::*;
#(
  parameter int XLEN            = 32,
  parameter int TAG_W           = 5,
  parameter int FMT_OVERRIDE_EN = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [2:0]       in_fmt,
  input  logic             in_fmt_vld,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  logic [XLEN-1:0]  w_imm;
  logic [2:0]       w_fmt;
  logic             w_ill;
  logic             w_acc;
  logic             w_main_free;

  logic             r_main_vld;
  logic [XLEN-1:0]  r_main_imm;
  logic [2:0]       r_main_fmt;
  logic             r_main_ill;
  logic [TAG_W-1:0] r_main_tag;

  logic             r_skid_vld;
  logic [XLEN-1:0]  r_skid_imm;
  logic [2:0]       r_skid_fmt;
  logic             r_skid_ill;
  logic [TAG_W-1:0] r_skid_tag;

  imm_fmt_decode #(
    .XLEN            (XLEN),
    .FMT_OVERRIDE_EN (FMT_OVERRIDE_EN)
  ) u_dec (
    .i_instr   (in_instr),
    .i_fmt     (in_fmt),
    .i_fmt_vld (in_fmt_vld),
    .o_imm     (w_imm),
    .o_fmt     (w_fmt),
    .o_illegal (w_ill)
  );

  // ready comes straight from a flop, so no comb path from out_ready
  assign in_ready    = !r_skid_vld;
  assign w_acc       = in_valid && in_ready;
  assign w_main_free = !r_main_vld || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_vld <= 1'b0;
      r_main_imm <= '0;
      r_main_fmt <= '0;
      r_main_ill <= 1'b0;
      r_main_tag <= '0;
      r_skid_vld <= 1'b0;
      r_skid_imm <= '0;
      r_skid_fmt <= '0;
      r_skid_ill <= 1'b0;
      r_skid_tag <= '0;
    end else if (flush) begin
      r_main_vld <= 1'b0;
      r_skid_vld <= 1'b0;
    end else if (w_main_free) begin
      // skid is older, so it wins; in_ready was low if skid held data
      if (r_skid_vld) begin
        r_main_vld <= 1'b1;
        r_main_imm <= r_skid_imm;
        r_main_fmt <= r_skid_fmt;
        r_main_ill <= r_skid_ill;
        r_main_tag <= r_skid_tag;
        r_skid_vld <= 1'b0;
      end else begin
        r_main_vld <= w_acc;
        if (w_acc) begin
          r_main_imm <= w_imm;
          r_main_fmt <= w_fmt;
          r_main_ill <= w_ill;
          r_main_tag <= in_tag;
        end
      end
    end else if (w_acc) begin
      r_skid_vld <= 1'b1;
      r_skid_imm <= w_imm;
      r_skid_fmt <= w_fmt;
      r_skid_ill <= w_ill;
      r_skid_tag <= in_tag;
    end
  end

  assign out_valid   = r_main_vld;
  assign out_imm     = r_main_imm;
  assign out_fmt     = r_main_fmt;
  assign out_illegal = r_main_ill;
  assign out_tag     = r_main_tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: three configurations driven in parallel and
// checked against a 2-deep FIFO reference model.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] instr = '0;
  logic [4:0]  tag = '0;
  logic [2:0]  fmt = '0;
  logic        fmt_vld = 1'b0;

  logic        a_rdy, a_vld, a_ill;
  logic [31:0] a_imm;
  logic [2:0]  a_fmt;
  logic [4:0]  a_tag;
  logic        b_rdy, b_vld, b_ill;
  logic [63:0] b_imm;
  logic [2:0]  b_fmt;
  logic [4:0]  b_tag;
  logic        c_rdy, c_vld, c_ill;
  logic [31:0] c_imm;
  logic [2:0]  c_fmt;
  logic [4:0]  c_tag;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(5), .FMT_OVERRIDE_EN(0)) u32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(a_rdy),
    .in_instr(instr), .in_tag(tag),
    .in_fmt(fmt), .in_fmt_vld(fmt_vld),
    .out_valid(a_vld), .out_ready(out_ready),
    .out_imm(a_imm), .out_fmt(a_fmt),
    .out_illegal(a_ill), .out_tag(a_tag));

  imm_gen_pipe #(.XLEN(64), .TAG_W(5), .FMT_OVERRIDE_EN(0)) u64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(b_rdy),
    .in_instr(instr), .in_tag(tag),
    .in_fmt(fmt), .in_fmt_vld(fmt_vld),
    .out_valid(b_vld), .out_ready(out_ready),
    .out_imm(b_imm), .out_fmt(b_fmt),
    .out_illegal(b_ill), .out_tag(b_tag));

  imm_gen_pipe #(.XLEN(32), .TAG_W(5), .FMT_OVERRIDE_EN(1)) uov (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(c_rdy),
    .in_instr(instr), .in_tag(tag),
    .in_fmt(fmt), .in_fmt_vld(fmt_vld),
    .out_valid(c_vld), .out_ready(out_ready),
    .out_imm(c_imm), .out_fmt(c_fmt),
    .out_illegal(c_ill), .out_tag(c_tag));

  typedef struct packed {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [4:0]  tag;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [63:0] got,
                     logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               nm, got, exp, $time);
    end
  endtask

  // reference: value of the immediate as a signed integer
  function automatic exp_t ref_dec(
    input logic [31:0] w, input logic [2:0] f,
    input logic fv, input bit x64, input bit ov,
    input logic [4:0] t);
    exp_t   e;
    int     k;
    longint v;
    if (ov && fv) k = int'(f);
    else begin
      case (w[6:0])
        7'h33: k = 0;
        7'h3B: k = x64 ? 0 : 7;
        7'h13, 7'h03, 7'h67,
        7'h73, 7'h0F: k = 1;
        7'h1B: k = x64 ? 1 : 7;
        7'h23: k = 2;
        7'h63: k = 3;
        7'h37, 7'h17: k = 4;
        7'h6F: k = 5;
        default: k = 7;
      endcase
    end
    v = 0;
    case (k)
      1: begin
        v = longint'(w[31:20]);
        if (w[31]) v -= 4096;
      end
      2: begin
        v = longint'(w[31:25]) * 32
          + longint'(w[11:7]);
        if (w[31]) v -= 4096;
      end
      3: begin
        v = longint'(w[7]) * 2048
          + longint'(w[30:25]) * 32
          + longint'(w[11:8]) * 2;
        if (w[31]) v -= 4096;
      end
      4: begin
        v = longint'(w[31:12]) * 4096;
        if (w[31]) v -= longint'(1) << 32;
      end
      5: begin
        v = longint'(w[19:12]) * 4096
          + longint'(w[20]) * 2048
          + longint'(w[30:21]) * 2;
        if (w[31]) v -= longint'(1) << 20;
      end
      default: v = 0;
    endcase
    e.imm = 64'(v);
    e.fmt = 3'(k);
    e.ill = (k > 5);
    e.tag = t;
    return e;
  endfunction

  task automatic cmp(string n, int sz, exp_t e,
    bit x64, logic vld, logic rdy, logic [63:0] imm,
    logic [2:0] f, logic ill, logic [4:0] t);
    logic [63:0] ei;
    ei = x64 ? e.imm : {32'h0, e.imm[31:0]};
    chk({n, "_vld"}, 64'(vld), 64'(sz > 0));
    chk({n, "_rdy"}, 64'(rdy), 64'(sz < 2));
    if (sz > 0 && vld) begin
      chk({n, "_imm"}, imm, ei);
      chk({n, "_fmt"}, 64'(f), 64'(e.fmt));
      chk({n, "_ill"}, 64'(ill), 64'(e.ill));
      chk({n, "_tag"}, 64'(t), 64'(e.tag));
    end
  endtask

  // scoreboard: a 2-deep FIFO, evaluated between edges
  always @(negedge clk) begin : mon
    exp_t ea, eb, ec;
    int   sa, sb, sc;
    if (!rst_n) begin
      qa.delete();
      qb.delete();
      qc.delete();
    end else begin
      sa = qa.size();
      sb = qb.size();
      sc = qc.size();
      ea = '0; eb = '0; ec = '0;
      if (sa > 0) ea = qa[0];
      if (sb > 0) eb = qb[0];
      if (sc > 0) ec = qc[0];
      cmp("a", sa, ea, 0, a_vld, a_rdy, 64'(a_imm),
          a_fmt, a_ill, a_tag);
      cmp("b", sb, eb, 1, b_vld, b_rdy, b_imm,
          b_fmt, b_ill, b_tag);
      cmp("c", sc, ec, 0, c_vld, c_rdy, 64'(c_imm),
          c_fmt, c_ill, c_tag);
      if (flush) begin
        qa.delete();
        qb.delete();
        qc.delete();
      end else begin
        if (out_ready && sa > 0) void'(qa.pop_front());
        if (out_ready && sb > 0) void'(qb.pop_front());
        if (out_ready && sc > 0) void'(qc.pop_front());
        if (in_valid && sa < 2)
          qa.push_back(ref_dec(instr, fmt, fmt_vld, 0, 0, tag));
        if (in_valid && sb < 2)
          qb.push_back(ref_dec(instr, fmt, fmt_vld, 1, 0, tag));
        if (in_valid && sc < 2)
          qc.push_back(ref_dec(instr, fmt, fmt_vld, 0, 1, tag));
      end
    end
  end

  // present a word and hold it until accepted (leaves in_valid high)
  task automatic send(logic [31:0] w, logic [2:0] f,
                      logic fv, logic [4:0] t, bit rnd);
    bit acc;
    int n;
    n = 0;
    instr = w; fmt = f; fmt_vld = fv; tag = t;
    in_valid = 1'b1;
    do begin
      if (rnd) begin
        out_ready = ($urandom_range(0, 3) != 0);
        flush = ($urandom_range(0, 31) == 0);
      end
      @(negedge clk);
      acc = a_rdy && !flush;
      @(posedge clk); #1;
      flush = 1'b0;
      n++;
    end while (!acc && n < 100);
    if (!acc) chk("send_timeout", 64'd0, 64'd1);
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [6:0]  ops [16];
    logic [31:0] r;
    logic [3:0]  i;
    ops = '{7'h33, 7'h3B, 7'h13, 7'h03, 7'h67, 7'h73,
            7'h0F, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h17,
            7'h6F, 7'h7F, 7'h00, 7'h5B};
    r = $urandom();
    i = 4'($urandom_range(0, 15));
    if ($urandom_range(0, 7) == 0) return r;
    return {r[31:7], ops[i]};
  endfunction

  initial begin : wdog
    #2000000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end

  initial begin : stim
    int t, cyc;
    bit acc;

    #1 rst_n = 1'b0;
    #1;
    chk("rst_vld", 64'(a_vld), 64'd0);
    chk("rst_rdy", 64'(a_rdy), 64'd1);
    chk("rst_imm", b_imm, 64'd0);
    chk("rst_fmt", 64'(a_fmt), 64'd0);
    chk("rst_ill", 64'(a_ill), 64'd0);
    chk("rst_tag", 64'(a_tag), 64'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;

    // sw x5,-4(x2)
    send(32'hFE512E23, 3'd0, 1'b0, 5'd1, 0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("sw_imm", 64'(a_imm), 64'hFFFFFFFC);
    chk("sw_fmt", 64'(a_fmt), 64'd2);
    chk("sw_ill", 64'(a_ill), 64'd0);
    @(posedge clk); #1;

    // jal x0,-8 then beq x0,x0,+16 back to back
    send(32'hFF9FF06F, 3'd0, 1'b0, 5'd2, 0);
    instr = 32'h00000863;
    tag = 5'd3;
    @(negedge clk);
    chk("jal_imm", 64'(a_imm), 64'hFFFFFFF8);
    chk("jal_fmt", 64'(a_fmt), 64'd5);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("beq_vld", 64'(a_vld), 64'd1);
    chk("beq_imm", 64'(a_imm), 64'h10);
    chk("beq_fmt", 64'(a_fmt), 64'd3);
    @(posedge clk); #1;

    // XLEN=64 lui and an unknown opcode
    send(32'h800000B7, 3'd0, 1'b0, 5'd4, 0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("lui64_imm", b_imm, 64'hFFFFFFFF80000000);
    chk("lui64_fmt", 64'(b_fmt), 64'd4);
    @(posedge clk); #1;
    send(32'h0000007F, 3'd0, 1'b0, 5'd5, 0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("ill64_imm", b_imm, 64'd0);
    chk("ill64_fmt", 64'(b_fmt), 64'd7);
    chk("ill64_ill", 64'(b_ill), 64'd1);
    @(posedge clk); #1;

    // explicit format override
    send(32'h00000863, 3'd1, 1'b1, 5'd6, 0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("ovr_fmt", 64'(c_fmt), 64'd1);
    chk("ovr_imm", 64'(c_imm), 64'd0);
    chk("ovr_ill", 64'(c_ill), 64'd0);
    chk("noovr_fmt", 64'(a_fmt), 64'd3);
    @(posedge clk); #1;
    send(32'h00000863, 3'd6, 1'b1, 5'd7, 0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("ovr6_ill", 64'(c_ill), 64'd1);
    @(posedge clk); #1;
    fmt_vld = 1'b0;

    // backpressure: tags 1..6, consumer stalled 3 cycles
    t = 1;
    cyc = 0;
    while (t <= 6 && cyc < 50) begin
      instr = rnd_instr();
      tag = 5'(t);
      in_valid = 1'b1;
      out_ready = (cyc >= 3);
      @(negedge clk);
      acc = a_rdy;
      if (cyc == 2) chk("bp_rdy_low", 64'(a_rdy), 64'd0);
      @(posedge clk); #1;
      if (acc) t++;
      cyc++;
    end
    chk("bp_all_sent", 64'(t), 64'd7);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // flush with both entries full and a word presented
    out_ready = 1'b0;
    send(rnd_instr(), 3'd0, 1'b0, 5'd10, 0);
    send(rnd_instr(), 3'd0, 1'b0, 5'd11, 0);
    tag = 5'd12;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("fl_vld", 64'(a_vld), 64'd0);
    chk("fl_rdy", 64'(a_rdy), 64'd1);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // asynchronous reset between edges
    out_ready = 1'b0;
    send(32'h00A00093, 3'd0, 1'b0, 5'd13, 0);
    in_valid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("arst_vld", 64'(a_vld), 64'd0);
    chk("arst_rdy", 64'(a_rdy), 64'd1);
    chk("arst_imm", 64'(a_imm), 64'd0);
    chk("arst_tag", 64'(a_tag), 64'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(32'h00A00093, 3'd0, 1'b0, 5'd14, 0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("arst_post_vld", 64'(a_vld), 64'd1);
    chk("arst_post_tag", 64'(a_tag), 64'd14);
    chk("arst_post_imm", 64'(a_imm), 64'd10);
    @(posedge clk); #1;

    // randomized traffic, backpressure and flushes
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        out_ready = ($urandom_range(0, 1) != 0);
        @(posedge clk); #1;
      end
      send(rnd_instr(), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 5'(i), 1);
    end

    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("drain_empty", 64'(a_vld), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
